somador_arbitro: RTL

//   Round-robin arbiter and sequencer that shares one combinational Somador (8-bit adder) between two requesters.

---
 rtl/somador_arbitro.sv | 106 ++++++++++
 1 files changed

// File: rtl/somador_arbitro.sv
// Round-robin arbiter sharing one external combinational adder between two requesters.
// Each grant runs OCIOSO -> SOMA -> ENTREGA; the sum is registered and returned with a one-cycle Ack.
//
// state   | meaning
// OCIOSO  | idle: arbitrate Req0/Req1, latch winner operands into Entrada1/Entrada2
// SOMA    | adder settled: capture Resultado into the winner's Res and raise its Ack
// ENTREGA | Ack visible for this cycle; clear it and hand priority to the other requester
module somador_arbitro #(
    parameter int LARGURA = 8
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Req0,
    input  logic [LARGURA-1:0] A0,
    input  logic [LARGURA-1:0] B0,
    output logic               Ack0,
    output logic [LARGURA-1:0] Res0,
    input  logic               Req1,
    input  logic [LARGURA-1:0] A1,
    input  logic [LARGURA-1:0] B1,
    output logic               Ack1,
    output logic [LARGURA-1:0] Res1,
    output logic [LARGURA-1:0] Entrada1,
    output logic [LARGURA-1:0] Entrada2,
    input  logic [LARGURA-1:0] Resultado,
    output logic               Ocupado
);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        SOMA    = 2'd1,
        ENTREGA = 2'd2
    } estado_t;

    estado_t            r_estado;
    logic               r_ptr;
    logic               r_id;
    logic               r_ack0;
    logic               r_ack1;
    logic [LARGURA-1:0] r_res0;
    logic [LARGURA-1:0] r_res1;
    logic [LARGURA-1:0] r_entrada1;
    logic [LARGURA-1:0] r_entrada2;

    logic               w_pedido;
    logic               w_ganha1;

    // r_ptr = 0 favours requester 0 when both ask at once
    assign w_pedido = Req0 | Req1;
    assign w_ganha1 = Req1 & (~Req0 | r_ptr);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_estado   <= OCIOSO;
            r_ptr      <= 1'b0;
            r_id       <= 1'b0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_res0     <= '0;
            r_res1     <= '0;
            r_entrada1 <= '0;
            r_entrada2 <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (w_pedido) begin
                        r_id       <= w_ganha1;
                        r_entrada1 <= w_ganha1 ? A1 : A0;
                        r_entrada2 <= w_ganha1 ? B1 : B0;
                        r_estado   <= SOMA;
                    end
                end
                SOMA: begin
                    if (r_id) begin
                        r_res1 <= Resultado;
                        r_ack1 <= 1'b1;
                    end else begin
                        r_res0 <= Resultado;
                        r_ack0 <= 1'b1;
                    end
                    r_estado <= ENTREGA;
                end
                ENTREGA: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_ptr    <= ~r_id;
                    r_estado <= OCIOSO;
                end
                default: begin
                    r_ack0   <= 1'b0;
                    r_ack1   <= 1'b0;
                    r_estado <= OCIOSO;
                end
            endcase
        end
    end

    assign Ack0     = r_ack0;
    assign Ack1     = r_ack1;
    assign Res0     = r_res0;
    assign Res1     = r_res1;
    assign Entrada1 = r_entrada1;
    assign Entrada2 = r_entrada2;
    assign Ocupado  = (r_estado == SOMA) || (r_estado == ENTREGA);

endmodule
